mmcm_ps_stepper: RTL and testbench

//  Drives the MMCM dynamic phase-shift port (psen/psincdec/psdone) for the detector clock wrapper.

---
 rtl/mmcm_ps_stepper.sv | 136 +++++++++++++
 tb/tb_mmcm_ps_stepper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_ps_stepper.sv
// Steps the MMCM dynamic phase shift one increment at a time until the
// tracked position reaches an accepted signed target.
module mmcm_ps_stepper #(
    parameter int POS_W       = 10,
    parameter int TIMEOUT_CYC = 64,
    parameter int SETTLE_CYC  = 8
) (
    input  logic             i_psclk,
    input  logic             i_reset_n,
    input  logic             i_locked,
    input  logic             i_tgt_valid,
    input  logic [POS_W-1:0] i_tgt_pos,
    output logic             o_tgt_ready,
    output logic             o_psen,
    output logic             o_psincdec,
    input  logic             i_psdone,
    output logic [POS_W-1:0] o_cur_pos,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PULSE,
        S_WAIT,
        S_SETTLE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [POS_W-1:0] r_tgt, w_tgt_nxt;
    logic [POS_W-1:0] r_pos, w_pos_nxt;
    logic             r_incdec, w_incdec_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err, w_err_nxt;
    logic             r_done, w_done_nxt;

    always_ff @(posedge i_psclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_tgt    <= '0;
            r_pos    <= '0;
            r_incdec <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tgt    <= w_tgt_nxt;
            r_pos    <= w_pos_nxt;
            r_incdec <= w_incdec_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Lock loss overrides every state: the MMCM restarts at zero phase.
    always_comb begin
        w_state_nxt  = r_state;
        w_tgt_nxt    = r_tgt;
        w_pos_nxt    = r_pos;
        w_incdec_nxt = r_incdec;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_done_nxt   = 1'b0;
        if (!i_locked) begin
            w_state_nxt = S_IDLE;
            w_pos_nxt   = '0;
            if (r_state != S_IDLE) begin
                w_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_tgt_valid) begin
                        w_tgt_nxt   = i_tgt_pos;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_pos == r_tgt) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_incdec_nxt = ($signed(r_tgt) > $signed(r_pos));
                        w_state_nxt  = S_PULSE;
                    end
                end
                S_PULSE: begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // psdone takes priority over an expiry in the same cycle.
                    if (i_psdone) begin
                        w_pos_nxt   = r_incdec ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SETTLE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign o_tgt_ready = (r_state == S_IDLE) & i_locked & i_reset_n;
    assign o_psen      = (r_state == S_PULSE);
    assign o_psincdec  = r_incdec;
    assign o_cur_pos   = r_pos;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_mmcm_ps_stepper.sv
// Scoreboard bench for mmcm_ps_stepper with a behavioural MMCM phase-shift
// responder and a move-level position model.
module tb_mmcm_ps_stepper;

    localparam int POS_W       = 10;
    localparam int TIMEOUT_CYC = 64;
    localparam int SETTLE_CYC  = 8;

    logic             psclk    = 1'b0;
    logic             reset_n  = 1'b0;
    logic             locked   = 1'b1;
    logic             tgtValid = 1'b0;
    logic [POS_W-1:0] tgtPos   = '0;
    logic             psdone   = 1'b0;
    logic             tgtReady;
    logic             psen;
    logic             psincdec;
    logic [POS_W-1:0] curPos;
    logic             busy;
    logic             done;
    logic             err;

    mmcm_ps_stepper #(
        .POS_W      (POS_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .i_psclk    (psclk),
        .i_reset_n  (reset_n),
        .i_locked   (locked),
        .i_tgt_valid(tgtValid),
        .i_tgt_pos  (tgtPos),
        .o_tgt_ready(tgtReady),
        .o_psen     (psen),
        .o_psincdec (psincdec),
        .i_psdone   (psdone),
        .o_cur_pos  (curPos),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 psclk = ~psclk;

    int cyc = 0;
    always @(posedge psclk) cyc <= cyc + 1;

    typedef struct {
        bit               isErr;
        logic [POS_W-1:0] pos;
        int               pulses;
    } exp_t;

    exp_t sbQ[$];

    int checks = 0;
    int passes = 0;

    logic [POS_W-1:0] modelPos = '0;
    bit  expDir      = 1'b0;
    int  movePulses  = 0;
    int  lastPsenCyc = 0;

    bit  respond   = 1'b1;
    bit  respRand  = 1'b0;
    bit  spurious  = 1'b0;
    int  respDelay = 12;
    int  mdlCnt    = 0;
    int  spCnt     = 0;

    bit  prevErr  = 1'b0;
    bit  prevPsen = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // MMCM responder: psdone a fixed or random number of cycles after psen,
    // optionally followed by a stray psdone three cycles later.
    initial begin
        forever begin
            @(negedge psclk);
            psdone = 1'b0;
            if (spCnt > 0) begin
                spCnt--;
                if (spCnt == 0) psdone = 1'b1;
            end
            if (mdlCnt > 0) begin
                mdlCnt--;
                if (mdlCnt == 0) begin
                    psdone = 1'b1;
                    if (spurious) spCnt = 3;
                end
            end
            if (psen && respond) mdlCnt = respRand ? int'($urandom_range(1, 20)) : respDelay;
        end
    end

    // Monitor: pops one expectation per done pulse or rising err.
    initial begin
        exp_t e;
        forever begin
            @(negedge psclk);
            if (!reset_n) begin
                prevErr  = 1'b0;
                prevPsen = 1'b0;
            end else begin
                if (psen) begin
                    movePulses++;
                    lastPsenCyc = cyc;
                    checkOutput("psen_width", prevPsen, 0);
                    checkOutput("psincdec", psincdec, expDir);
                end
                if (done || (err && !prevErr)) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_event", 1, 0);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("event_is_err", err, e.isErr);
                        checkOutput("event_pos", curPos, e.pos);
                        checkOutput("event_pulses", movePulses, e.pulses);
                    end
                end
                prevErr  = err;
                prevPsen = psen;
            end
        end
    end

    // kind 0: normal move, 1: psdone never returns, 2: lock dropped after lockPulses steps
    task automatic applyStimulus(input logic [POS_W-1:0] tgt, input int kind, input int lockPulses,
                                 input bit hold, output int accCyc);
        exp_t e;
        int   t, c, d;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge psclk);
            if (tgtReady) begin
                ok = 1'b1;
                break;
            end
        end
        accCyc = cyc;
        if (!ok) begin
            checkOutput("ready_wait_timeout", 0, 1);
            return;
        end
        tgtPos   = tgt;
        tgtValid = 1'b1;
        t = $signed(tgt);
        c = $signed(modelPos);
        d = t - c;
        expDir     = (d > 0);
        movePulses = 0;
        case (kind)
            1: e = '{isErr: 1'b1, pos: modelPos, pulses: 1};
            2: begin
                e = '{isErr: 1'b1, pos: '0, pulses: lockPulses};
                modelPos = '0;
            end
            default: begin
                e = '{isErr: 1'b0, pos: tgt, pulses: (d < 0) ? -d : d};
                modelPos = tgt;
            end
        endcase
        sbQ.push_back(e);
        @(negedge psclk);
        if (hold) tgtPos = ~tgt;
        else tgtValid = 1'b0;
    endtask

    task automatic waitEvent(output int evCyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge psclk);
            if (done || err) begin
                ok = 1'b1;
                break;
            end
        end
        evCyc    = cyc;
        tgtValid = 1'b0;
        if (!ok) checkOutput("event_wait_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, ev, dl;
        bit ok;
        logic [POS_W-1:0] rt;

        repeat (3) @(negedge psclk);
        checkOutput("rst_psen", psen, 0);
        checkOutput("rst_psincdec", psincdec, 0);
        checkOutput("rst_cur_pos", curPos, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_tgt_ready", tgtReady, 0);
        reset_n = 1'b1;
        @(negedge psclk);
        checkOutput("ready_after_reset", tgtReady, 1);

        applyStimulus(10'd3, 0, 0, 1'b0, acc);
        waitEvent(ev);
        checkOutput("t1_err", err, 0);

        applyStimulus(10'h3FE, 0, 0, 1'b0, acc);
        waitEvent(ev);

        applyStimulus(10'h3FE, 0, 0, 1'b0, acc);
        waitEvent(ev);
        checkOutput("equal_target_done_latency", ev - acc, 2);

        respDelay = TIMEOUT_CYC;
        applyStimulus(10'h3FF, 0, 0, 1'b0, acc);
        waitEvent(ev);
        checkOutput("psdone_at_expiry_no_err", err, 0);
        respDelay = 12;

        respond = 1'b0;
        applyStimulus(10'd5, 1, 0, 1'b0, acc);
        waitEvent(ev);
        dl = ev - lastPsenCyc;
        checkOutput("timeout_latency", (dl == TIMEOUT_CYC) || (dl == TIMEOUT_CYC + 1), 1);
        checkOutput("timeout_busy", busy, 0);
        checkOutput("timeout_no_done", done, 0);
        respond = 1'b1;
        repeat (3) @(negedge psclk);
        checkOutput("err_sticky", err, 1);
        applyStimulus(10'h3FF, 0, 0, 1'b0, acc);
        checkOutput("err_cleared_on_accept", err, 0);
        waitEvent(ev);

        applyStimulus(10'd9, 2, 3, 1'b0, acc);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge psclk);
            if (movePulses >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("third_pulse_wait", 0, 1);
        repeat (2) @(negedge psclk);
        locked = 1'b0;
        waitEvent(ev);
        checkOutput("lock_loss_pos", curPos, 0);
        checkOutput("lock_loss_busy", busy, 0);
        checkOutput("lock_loss_ready", tgtReady, 0);
        repeat (20) @(negedge psclk);
        checkOutput("ready_while_unlocked", tgtReady, 0);
        locked = 1'b1;
        @(negedge psclk);
        checkOutput("ready_after_relock", tgtReady, 1);
        checkOutput("pos_after_relock", curPos, 0);

        spurious = 1'b1;
        applyStimulus(10'd4, 0, 0, 1'b1, acc);
        waitEvent(ev);
        spurious = 1'b0;
        repeat (10) @(negedge psclk);
        checkOutput("held_valid_not_accepted", busy, 0);
        checkOutput("spurious_ignored_pos", curPos, 4);

        respRand = 1'b1;
        for (int n = 0; n < 8; n++) begin
            rt = modelPos + POS_W'($urandom_range(0, 30)) - POS_W'(15);
            applyStimulus(rt, 0, 0, 1'b0, acc);
            waitEvent(ev);
        end
        respRand = 1'b0;

        respDelay = 12;
        applyStimulus(modelPos + POS_W'(5), 0, 0, 1'b0, acc);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge psclk);
            if (psen) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("psen_wait", 0, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_psen", psen, 0);
        checkOutput("midreset_psincdec", psincdec, 0);
        checkOutput("midreset_cur_pos", curPos, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_err", err, 0);
        checkOutput("midreset_ready", tgtReady, 0);
        sbQ.delete();
        modelPos = '0;
        repeat (2) @(negedge psclk);
        reset_n = 1'b1;
        repeat (25) @(negedge psclk);
        checkOutput("late_psdone_ignored_pos", curPos, 0);
        checkOutput("late_psdone_ignored_busy", busy, 0);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
